// File: rtl/mw_eeprom_resp.sv
// mw_eeprom_resp -- Microwire (93C46-class) serial EEPROM responder.
//
// Device end of the 3-wire Microwire bus. CS/SK/DI are asynchronous to clk and
// are double-flopped. SK is edge-detected on clk. The responder decodes the
// start bit, the opcode and the address, shifts read data out MSB first, and
// models program/erase with a busy/ready status that is shown on DO.
//
// Ports
//   clk    in   system clock, all logic on posedge
//   rst_n  in   synchronous active-low reset
//   cs     in   chip select, active high (async)
//   sk     in   serial clock from initiator (async, <= clk/4)
//   di     in   serial data in, sampled on SK rise
//   do_o   out  serial data out / ready status
//   do_oe  out  1 = responder drives do_o
//   busy   out  1 = program/erase in progress
module mw_eeprom_resp #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned BUSY_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cs,
  input  logic sk,
  input  logic di,
  output logic do_o,
  output logic do_oe,
  output logic busy
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned CNT_W  = $clog2(DATA_W + ADDR_W + 1);
  localparam int unsigned BCNT_W = $clog2(BUSY_CYCLES + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_OPC  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DIN  = 3'd3;
  localparam logic [2:0] S_DOUT = 3'd4;
  localparam logic [2:0] S_PROG = 3'd5;

  localparam logic [1:0] OP_EXT   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_ERASE = 2'b11;

  localparam logic [1:0] EXT_EWDS = 2'b00;
  localparam logic [1:0] EXT_WRAL = 2'b01;
  localparam logic [1:0] EXT_ERAL = 2'b10;
  localparam logic [1:0] EXT_EWEN = 2'b11;

  logic              r_cs_m, r_cs_s;
  logic              r_sk_m, r_sk_s, r_sk_d;
  logic              r_di_m, r_di_s;
  logic [2:0]        r_state;
  logic [1:0]        r_opc;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_sr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_done;   // ADDR state: command decoded, waiting for cs fall
  logic              r_hold;   // IDLE: still showing "ready" until cs goes low
  logic              r_wen;
  logic              r_busy;
  logic [BCNT_W-1:0] r_bcnt;
  logic              r_do;
  logic              r_oe;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_sk_rise;
  logic [ADDR_W-1:0] w_addr_nx;
  logic [ADDR_W-1:0] w_addr_inc;
  logic              w_er_op;
  logic              w_all;
  logic              w_prog_start;
  logic [DATA_W-1:0] w_prog_data;

  always_comb begin
    w_sk_rise  = r_sk_s & ~r_sk_d;
    w_addr_nx  = {r_addr[ADDR_W-2:0], r_di_s};
    w_addr_inc = r_addr + ADDR_W'(1);
    w_er_op    = (r_opc == OP_ERASE) ||
                 ((r_opc == OP_EXT) && (r_addr[ADDR_W-1 -: 2] == EXT_ERAL));
    w_all      = (r_opc == OP_EXT);
    // A program starts on cs fall only after a complete WRITE/WRAL or a decoded
    // ERASE/ERAL, and only while writes are enabled.
    w_prog_start = ~r_cs_s && r_wen && (r_state != S_PROG) &&
                   (((r_state == S_DIN) && (r_cnt == CNT_W'(DATA_W))) ||
                    ((r_state == S_ADDR) && r_done && w_er_op));
    w_prog_data  = (r_state == S_ADDR) ? '1 : r_sr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cs_m <= 1'b0;
      r_cs_s <= 1'b0;
      r_sk_m <= 1'b0;
      r_sk_s <= 1'b0;
      r_sk_d <= 1'b0;
      r_di_m <= 1'b0;
      r_di_s <= 1'b0;
    end else begin
      r_cs_m <= cs;
      r_cs_s <= r_cs_m;
      r_sk_m <= sk;
      r_sk_s <= r_sk_m;
      r_sk_d <= r_sk_s;
      r_di_m <= di;
      r_di_s <= r_di_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '1;
    end else if (w_prog_start) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_all || (r_addr == ADDR_W'(i))) r_mem[i] <= w_prog_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_opc   <= '0;
      r_addr  <= '0;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_hold  <= 1'b0;
      r_wen   <= 1'b0;
      r_busy  <= 1'b0;
      r_bcnt  <= '0;
      r_do    <= 1'b0;
      r_oe    <= 1'b0;
    end else if (r_state == S_PROG) begin
      // SK/DI ignored; cs only decides whether status is driven.
      r_oe <= r_cs_s;
      if (r_bcnt == BCNT_W'(1)) begin
        r_busy  <= 1'b0;
        r_bcnt  <= '0;
        r_state <= S_IDLE;
        r_hold  <= r_cs_s;
        r_do    <= r_cs_s;
      end else begin
        r_bcnt <= r_bcnt - BCNT_W'(1);
        r_do   <= 1'b0;
      end
    end else if (!r_cs_s) begin
      r_state <= S_IDLE;
      r_oe    <= 1'b0;
      r_do    <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_hold  <= 1'b0;
      if (w_prog_start) begin
        r_state <= S_PROG;
        r_busy  <= 1'b1;
        r_bcnt  <= BCNT_W'(BUSY_CYCLES);
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_hold) begin
            r_oe <= 1'b1;
            r_do <= 1'b1;
          end else if (w_sk_rise && r_di_s && !r_busy) begin
            r_state <= S_OPC;
            r_cnt   <= '0;
            r_oe    <= 1'b0;
            r_do    <= 1'b0;
          end
        end
        S_OPC: begin
          if (w_sk_rise) begin
            r_opc <= {r_opc[0], r_di_s};
            if (r_cnt == CNT_W'(1)) begin
              r_state <= S_ADDR;
              r_cnt   <= '0;
              r_done  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_ADDR: begin
          if (w_sk_rise && !r_done) begin
            r_addr <= w_addr_nx;
            if (r_cnt == CNT_W'(ADDR_W - 1)) begin
              r_cnt <= '0;
              case (r_opc)
                OP_READ: begin
                  r_state <= S_DOUT;
                  r_oe    <= 1'b1;
                  r_do    <= 1'b0;
                  r_sr    <= r_mem[w_addr_nx];
                end
                OP_WRITE: r_state <= S_DIN;
                OP_ERASE: r_done  <= 1'b1;
                default: begin
                  case (w_addr_nx[ADDR_W-1 -: 2])
                    EXT_WRAL: r_state <= S_DIN;
                    EXT_ERAL: r_done  <= 1'b1;
                    EXT_EWEN: begin
                      r_wen  <= 1'b1;
                      r_done <= 1'b1;
                    end
                    default: begin
                      r_wen  <= 1'b0;
                      r_done <= 1'b1;
                    end
                  endcase
                end
              endcase
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_DIN: begin
          if (w_sk_rise && (r_cnt != CNT_W'(DATA_W))) begin
            r_sr  <= {r_sr[DATA_W-2:0], r_di_s};
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DOUT: begin
          // After the LSB, the next word is fetched so the following rise
          // presents its MSB with no extra dummy bit.
          if (w_sk_rise) begin
            r_do <= r_sr[DATA_W-1];
            if (r_cnt == CNT_W'(DATA_W - 1)) begin
              r_cnt  <= '0;
              r_addr <= w_addr_inc;
              r_sr   <= r_mem[w_addr_inc];
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
              r_sr  <= {r_sr[DATA_W-2:0], 1'b0};
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign do_o  = r_do;
  assign do_oe = r_oe;
  assign busy  = r_busy;

endmodule

// File: tb/tb_mw_eeprom_resp.sv
module tb_mw_eeprom_resp;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 16;
  localparam int unsigned BC = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic cs    = 1'b0;
  logic sk    = 1'b0;
  logic di    = 1'b0;
  logic do_o, do_oe, busy;

  mw_eeprom_resp #(.ADDR_W(AW), .DATA_W(DW), .BUSY_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .sk(sk), .di(di),
    .do_o(do_o), .do_oe(do_oe), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    bit    c_od;
    bit    e_oe;
    bit    e_do;
    bit    c_b;
    bit    e_b;
  } exp_t;

  exp_t        sb[$];
  event        ev_probe;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [DW-1:0] m_mem [1 << AW];
  bit            m_wen;

  // Monitor: samples on every SK fall and on every explicit probe.
  initial begin : monitor
    exp_t e;
    wait (rst_n === 1'b1);
    forever begin
      @(negedge sk or ev_probe);
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_sample: nothing queued at t=%0t", $time);
      end else begin
        e = sb.pop_front();
        if (e.c_od) begin
          n_vec++;
          if ({do_oe, do_o} !== {e.e_oe, e.e_do}) begin
            n_err++;
            $display("FAIL %s: oe,do got %b%b expected %b%b (t=%0t)",
                     e.nm, do_oe, do_o, e.e_oe, e.e_do, $time);
          end
        end
        if (e.c_b) begin
          n_vec++;
          if (busy !== e.e_b) begin
            n_err++;
            $display("FAIL %s: busy got %b expected %b (t=%0t)", e.nm, busy, e.e_b, $time);
          end
        end
      end
    end
  end

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish in cycle budget");
    $fatal(1);
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input string nm, input bit c_od, input bit eo, input bit ed,
                      input bit c_b, input bit eb);
    exp_t x;
    x.nm = nm; x.c_od = c_od; x.e_oe = eo; x.e_do = ed; x.c_b = c_b; x.e_b = eb;
    sb.push_back(x);
  endtask

  task automatic probe(input string nm, input bit c_od, input bit eo, input bit ed,
                       input bit c_b, input bit eb);
    push(nm, c_od, eo, ed, c_b, eb);
    -> ev_probe;
  endtask

  // One SK period; the expectation applies to DO after this rise.
  task automatic sk_bit(input logic d, input bit eo, input bit ed, input string nm);
    push(nm, 1'b1, eo, ed, 1'b0, 1'b0);
    di = d;
    tick(4);
    sk = 1'b1;
    tick(4);
    sk = 1'b0;
    tick(1);
  endtask

  task automatic model_reset();
    for (int unsigned i = 0; i < (1 << AW); i++) m_mem[i] = '1;
    m_wen = 1'b0;
  endtask

  task automatic send_hdr(input logic [1:0] opc, input logic [AW-1:0] a, input bit is_rd,
                          input int unsigned nlead);
    logic [1:0]    o;
    logic [AW-1:0] aa;
    o  = opc;
    aa = a;
    cs = 1'b1;
    tick(3);
    for (int unsigned k = 0; k < nlead; k++) sk_bit(1'b0, 1'b0, 1'b0, "lead0");
    sk_bit(1'b1, 1'b0, 1'b0, "start");
    sk_bit(o[1], 1'b0, 1'b0, "opc");
    sk_bit(o[0], 1'b0, 1'b0, "opc");
    for (int i = int'(AW) - 1; i >= 0; i--)
      sk_bit(aa[i], (i == 0) && is_rd, 1'b0, (i == 0 && is_rd) ? "dummy" : "addr");
  endtask

  // cs fall at negedge N: busy rises after N+2 and is high for exactly BC clocks.
  task automatic end_cmd(input bit progs, input string nm);
    cs = 1'b0;
    di = 1'b0;
    tick(2);
    probe({nm, "_busy_pre"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    probe({nm, "_start"}, 1'b1, 1'b0, 1'b0, 1'b1, progs);
    if (progs) begin
      tick(BC - 1);
      probe({nm, "_busy_last"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick(1);
      probe({nm, "_busy_done"}, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    tick(6);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int unsigned nw, input int unsigned nlead);
    logic [DW-1:0] w;
    logic [AW-1:0] aa;
    aa = a;
    send_hdr(2'b10, a, 1'b1, nlead);
    for (int unsigned k = 0; k < nw; k++) begin
      w = m_mem[aa];
      for (int b = int'(DW) - 1; b >= 0; b--)
        sk_bit(1'($urandom_range(0, 1)), 1'b1, w[b], $sformatf("rd_a%0d_b%0d", aa, b));
      aa = aa + 1'b1;
    end
    end_cmd(1'b0, "rd_end");
  endtask

  task automatic send_data(input logic [DW-1:0] d, input int unsigned nextra);
    logic [DW-1:0] dd;
    dd = d;
    for (int b = int'(DW) - 1; b >= 0; b--) sk_bit(dd[b], 1'b0, 1'b0, "din");
    for (int unsigned k = 0; k < nextra; k++) sk_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0, "din_extra");
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int unsigned nextra);
    send_hdr(2'b01, a, 1'b0, 0);
    send_data(d, nextra);
    if (m_wen) m_mem[a] = d;
    end_cmd(m_wen, "wr");
  endtask

  task automatic do_wral(input logic [DW-1:0] d);
    send_hdr(2'b00, {2'b01, 4'($urandom)}, 1'b0, 0);
    send_data(d, 0);
    if (m_wen) for (int unsigned i = 0; i < (1 << AW); i++) m_mem[i] = d;
    end_cmd(m_wen, "wral");
  endtask

  task automatic do_erase(input logic [AW-1:0] a);
    send_hdr(2'b11, a, 1'b0, 0);
    if (m_wen) m_mem[a] = '1;
    end_cmd(m_wen, "erase");
  endtask

  task automatic do_eral();
    send_hdr(2'b00, {2'b10, 4'($urandom)}, 1'b0, 0);
    if (m_wen) for (int unsigned i = 0; i < (1 << AW); i++) m_mem[i] = '1;
    end_cmd(m_wen, "eral");
  endtask

  task automatic do_ewen(input bit en);
    send_hdr(2'b00, {en ? 2'b11 : 2'b00, 4'($urandom)}, 1'b0, 0);
    m_wen = en;
    end_cmd(1'b0, en ? "ewen" : "ewds");
  endtask

  initial begin : stim
    int unsigned r;
    model_reset();
    tick(4);
    rst_n = 1'b1;
    tick(2);
    probe("reset_state", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Erased part reads all ones.
    do_read(6'd5, 1, 0);

    // Writes are ignored until EWEN.
    do_write(6'd3, 16'hA55A, 0);
    do_read(6'd3, 1, 0);

    // Program with cs raised during busy: status 0 then ready 1, held until cs low.
    do_ewen(1'b1);
    send_hdr(2'b01, 6'd3, 1'b0, 0);
    send_data(16'hA55A, 2);
    m_mem[3] = 16'hA55A;
    cs = 1'b0;
    di = 1'b0;
    tick(3);
    probe("poll_start", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(7);
    cs = 1'b1;
    tick(10);
    probe("poll_busy", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(46);
    probe("poll_busy_last", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(1);
    probe("poll_ready", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(5);
    probe("poll_hold", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    sk_bit(1'b1, 1'b1, 1'b1, "hold_no_start");
    sk_bit(1'b1, 1'b1, 1'b1, "hold_no_start");
    sk_bit(1'b0, 1'b1, 1'b1, "hold_no_start");
    cs = 1'b0;
    tick(4);
    probe("poll_release", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(4);
    do_read(6'd3, 1, 1);

    // Sequential read wraps from the top address to 0.
    do_write(6'd63, 16'h1234, 0);
    do_write(6'd0, 16'h5678, 0);
    do_read(6'd63, 2, 0);

    // Aborted command has no side effect.
    cs = 1'b1;
    tick(3);
    sk_bit(1'b1, 1'b0, 1'b0, "part_start");
    sk_bit(1'b0, 1'b0, 1'b0, "part_opc");
    sk_bit(1'b1, 1'b0, 1'b0, "part_opc");
    sk_bit(1'b0, 1'b0, 1'b0, "part_addr");
    sk_bit(1'b0, 1'b0, 1'b0, "part_addr");
    sk_bit(1'b0, 1'b0, 1'b0, "part_addr");
    cs = 1'b0;
    tick(5);
    probe("part_idle", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(3);
    do_read(6'd3, 1, 0);

    // Reset during a program aborts it and restores the erased array.
    send_hdr(2'b01, 6'd10, 1'b0, 0);
    send_data(16'h0BAD, 0);
    cs = 1'b0;
    di = 1'b0;
    tick(3);
    probe("rstprog_busy", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(9);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    model_reset();
    tick(1);
    probe("rstprog_after", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(3);
    do_read(6'd3, 1, 0);
    do_write(6'd3, 16'h1111, 0);
    do_read(6'd3, 1, 0);

    // Whole-array operations.
    do_ewen(1'b1);
    do_wral(16'h00FF);
    do_read(6'd0, 1, 0);
    do_read(6'd63, 1, 0);
    do_eral();
    do_read(6'd0, 1, 0);
    do_read(6'd63, 1, 0);

    // Randomized mix against the array model.
    for (int unsigned n = 0; n < 30; n++) begin
      r = $urandom_range(0, 11);
      case (r)
        0, 1, 2, 3: do_read(6'($urandom), $urandom_range(1, 2), $urandom_range(0, 2));
        4, 5, 6:    do_write(6'($urandom), 16'($urandom), $urandom_range(0, 2));
        7, 8:       do_ewen(1'b1);
        9:          do_ewen(1'b0);
        10:         do_erase(6'($urandom));
        default:    if ($urandom_range(0, 1) == 0) do_wral(16'($urandom)); else do_eral();
      endcase
    end
    do_read(6'd62, 2, 0);

    for (int unsigned k = 0; k < 100 && sb.size() != 0; k++) tick(1);
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations never sampled, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
